mac_array_engine: RTL and testbench

- Parametrised successor of the fixed 4-lane mac/acc pair in the conv datapath.
- Takes packed ifm/weight words of LANES lanes, does signed multiply, adder-tree reduction and accumulation over a configurable number of beats per output neuron.
- Scales, optionally ReLUs and saturates the result, then hands it to the output buffer with a valid/ready handshake and an auto-incrementing output address.
- Sits between the ifm/weight BRAM readers and the output BRAM writer, and replaces the clear/enable control of the old accumulator.

---
 rtl/mac_pkg.sv | 38 +++
 rtl/mac_array_engine_tree.sv | 39 +++
 rtl/mac_array_engine.sv | 198 +++++++++++++++++++
 tb/tb_mac_array_engine.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC array engine: FSM states, clog2 and
// signed saturation used when forming the output word.
package mac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_OUT
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Clamp a signed value into the range of a w-bit signed word
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int unsigned         w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] res;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        res = value;
        if (value > hi) begin
            res = hi;
        end else if (value < lo) begin
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_array_engine_tree.sv
// One registered stage of signed reduction: sums LANES packed products into
// a SUMW-wide result and forwards a valid bit alongside it.
module mac_adder_tree
    import mac_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned PRODW = 32,
    parameter int unsigned SUMW  = PRODW + clog2(LANES)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [LANES*PRODW-1:0]   prods,
    output logic                     out_valid,
    output logic signed [SUMW-1:0]   sum
);

    logic signed [SUMW-1:0] sum_c;

    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            sum_c = sum_c + SUMW'($signed(prods[i*PRODW +: PRODW]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum <= sum_c;
            end
        end
    end

endmodule

// File: rtl/mac_array_engine.sv
// Multi-lane signed MAC engine: per-beat products, adder-tree reduction and
// accumulation per neuron, then shift/ReLU/saturate and a valid/ready output.
module mac_array_engine
    import mac_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned ACCW  = 40,
    parameter int unsigned OUTW  = 16,
    parameter int unsigned LENW  = 12,
    parameter int unsigned AW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LENW-1:0]       cfg_len,
    input  logic [LENW-1:0]       cfg_neurons,
    input  logic [5:0]            cfg_shift,
    input  logic                  cfg_relu,
    input  logic [AW-1:0]         cfg_base,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   ifm_data,
    input  logic [LANES*DW-1:0]   w_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUTW-1:0]       out_data,
    output logic [AW-1:0]         out_addr,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned PRODW = 2 * DW;
    localparam int unsigned SUMW  = PRODW + clog2(LANES);

    state_e state_q, state_d;

    logic [LENW-1:0]          len_q, neurons_q, beat_q, beat_d, neuron_q, neuron_d;
    logic [5:0]               shift_q;
    logic                     relu_q;
    logic signed [ACCW-1:0]   acc_q;
    logic                     s1_valid_q;
    logic [LANES*PRODW-1:0]   s1_prod_q, prod_c;
    logic                     s2_valid;
    logic signed [SUMW-1:0]   s2_sum;
    logic signed [DW-1:0]     lane_a, lane_w;
    logic signed [ACCW-1:0]   shifted;
    logic [OUTW-1:0]          result;
    logic                     beat_fire, acc_clr, cfg_load;
    logic                     in_ready_d, out_valid_d, busy_d, done_d;
    logic [OUTW-1:0]          out_data_d;
    logic [AW-1:0]            out_addr_d;

    assign beat_fire = in_valid & in_ready;

    // Lane 0 sits in the MSBs of both input words
    always_comb begin
        prod_c = '0;
        lane_a = '0;
        lane_w = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_a = ifm_data[(LANES-1-i)*DW +: DW];
            lane_w = w_data[(LANES-1-i)*DW +: DW];
            prod_c[i*PRODW +: PRODW] = PRODW'(lane_a) * PRODW'(lane_w);
        end
    end

    mac_adder_tree #(
        .LANES (LANES),
        .PRODW (PRODW),
        .SUMW  (SUMW)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid_q),
        .prods     (s1_prod_q),
        .out_valid (s2_valid),
        .sum       (s2_sum)
    );

    // Floor shift, optional ReLU, then clamp into the output word
    always_comb begin
        shifted = acc_q >>> shift_q;
        if (relu_q && (shifted < 0)) begin
            shifted = '0;
        end
        result = OUTW'(sat_signed(64'(shifted), OUTW));
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_addr_d  = out_addr;
        busy_d      = busy;
        done_d      = 1'b0;
        beat_d      = beat_q;
        neuron_d    = neuron_q;
        acc_clr     = 1'b0;
        cfg_load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cfg_load   = 1'b1;
                    acc_clr    = 1'b1;
                    beat_d     = '0;
                    neuron_d   = '0;
                    out_addr_d = cfg_base;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat_fire) begin
                    beat_d = beat_q + LENW'(1);
                    if (beat_q + LENW'(1) == len_q) begin
                        in_ready_d = 1'b0;
                        state_d    = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // Last beat has landed in the accumulator once S1 and S2 are empty
                if (!s1_valid_q && !s2_valid) begin
                    out_valid_d = 1'b1;
                    out_data_d  = result;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_clr     = 1'b1;
                    out_addr_d  = out_addr + AW'(1);
                    if (neuron_q + LENW'(1) == neurons_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        neuron_d   = neuron_q + LENW'(1);
                        beat_d     = '0;
                        in_ready_d = 1'b1;
                        state_d    = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            neurons_q  <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            beat_q     <= '0;
            neuron_q   <= '0;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            neuron_q   <= neuron_d;
            in_ready   <= in_ready_d;
            out_valid  <= out_valid_d;
            out_data   <= out_data_d;
            out_addr   <= out_addr_d;
            busy       <= busy_d;
            done       <= done_d;
            s1_valid_q <= beat_fire;
            if (beat_fire) begin
                s1_prod_q <= prod_c;
            end
            if (cfg_load) begin
                len_q     <= (cfg_len == '0) ? LENW'(1) : cfg_len;
                neurons_q <= (cfg_neurons == '0) ? LENW'(1) : cfg_neurons;
                shift_q   <= cfg_shift;
                relu_q    <= cfg_relu;
            end
            if (acc_clr) begin
                acc_q <= '0;
            end else if (s2_valid) begin
                acc_q <= acc_q + ACCW'(s2_sum);
            end
        end
    end

endmodule

// File: tb/tb_mac_array_engine.sv
// Scoreboard bench for mac_array_engine: driver pushes expected results from
// an arithmetic reference model, a monitor pops and compares on each handshake.
module tb_mac_array_engine;

    localparam int LANES = 4;
    localparam int DW    = 16;
    localparam int ACCW  = 40;
    localparam int OUTW  = 16;
    localparam int LENW  = 12;
    localparam int AW    = 16;

    logic                clk, rst, start;
    logic [LENW-1:0]     cfg_len, cfg_neurons;
    logic [5:0]          cfg_shift;
    logic                cfg_relu;
    logic [AW-1:0]       cfg_base;
    logic                in_valid, in_ready;
    logic [LANES*DW-1:0] ifm_data, w_data;
    logic                out_valid, out_ready;
    logic [OUTW-1:0]     out_data;
    logic [AW-1:0]       out_addr;
    logic                busy, done;

    mac_array_engine #(
        .LANES(LANES), .DW(DW), .ACCW(ACCW), .OUTW(OUTW), .LENW(LENW), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_len(cfg_len), .cfg_neurons(cfg_neurons), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .cfg_base(cfg_base),
        .in_valid(in_valid), .in_ready(in_ready),
        .ifm_data(ifm_data), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [OUTW-1:0] data;
        logic [AW-1:0]   addr;
        bit              last;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    int   jobs = 0;
    int   hs_in_job = 0;
    int   stall_cnt = 0;
    bit   stall_arm = 0;
    bit   bp = 0;
    logic signed [DW-1:0] pat_ifm [LANES];
    logic signed [DW-1:0] pat_w   [LANES];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Floor division by 2^shift, ReLU, then clamp to the signed output range
    function automatic logic [OUTW-1:0] model(input longint acc, input int shift, input bit relu);
        longint d, r;
        d = longint'(1) <<< shift;
        r = acc / d;
        if (acc < 0 && (acc % d) != 0) r = r - 1;
        if (relu && r < 0) r = 0;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return OUTW'(r);
    endfunction

    // Backpressure driver; changes only just after the rising edge
    always @(posedge clk) begin
        #1;
        if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
        end else if (stall_arm && out_valid && hs_in_job == 1) begin
            stall_arm = 0;
            stall_cnt = 4;
            out_ready = 1'b0;
        end else begin
            out_ready = bp ? ($urandom % 3 != 0) : 1'b1;
        end
    end

    logic            prev_stall = 1'b0;
    logic [OUTW-1:0] prev_data;
    logic [AW-1:0]   prev_addr;
    int              chk_done = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            chk_done   = 0;
        end else begin
            if (done) done_cnt++;
            if (chk_done != 0) begin
                check("done_after_hs", done, chk_done == 2);
                if (chk_done == 2) check("busy_after_last", busy, 0);
                chk_done = 0;
            end
            if (out_valid) begin
                if (prev_stall) begin
                    check("stall_data_stable", out_data, prev_data);
                    check("stall_addr_stable", out_addr, prev_addr);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("out_unexpected");
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_addr", out_addr, e.addr);
                        chk_done = e.last ? 2 : 1;
                    end
                    hs_in_job++;
                end
                prev_stall = !out_ready;
                prev_data  = out_data;
                prev_addr  = out_addr;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic drive_beat(input logic signed [DW-1:0] a[LANES], input logic signed [DW-1:0] b[LANES],
                              output bit ok);
        int t;
        for (int l = 0; l < LANES; l++) begin
            ifm_data[(LANES-1-l)*DW +: DW] = a[l];
            w_data[(LANES-1-l)*DW +: DW]   = b[l];
        end
        in_valid = 1'b1;
        t = 0;
        while (in_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        ok = (t < 300);
        if (ok) @(negedge clk);
    endtask

    task automatic run_job(input int len, input int nn, input int shift, input bit relu,
                           input logic [AW-1:0] base, input int mode, input int gaps,
                           input bit stall, input bit spur);
        int el, en, acc_cnt, t;
        bit ok;
        longint acc;
        logic signed [DW-1:0] bi[16][LANES];
        logic signed [DW-1:0] bw[16][LANES];
        el = (len == 0) ? 1 : len;
        en = (nn == 0) ? 1 : nn;
        @(negedge clk);
        cfg_len = LENW'(len); cfg_neurons = LENW'(nn); cfg_shift = 6'(shift);
        cfg_relu = relu; cfg_base = base; start = 1'b1;
        hs_in_job = 0; stall_arm = stall; jobs++;
        @(negedge clk);
        start = 1'b0;
        acc_cnt = 0;
        for (int n = 0; n < en; n++) begin
            if (spur && n == 1) begin
                cfg_base = 16'hDEAD; cfg_len = 7; cfg_neurons = 9; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            acc = 0;
            for (int b = 0; b < el; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    case (mode)
                        0: begin
                            bi[b][l] = DW'($urandom_range(0, 15)) - DW'(8);
                            bw[b][l] = DW'($urandom_range(0, 15)) - DW'(8);
                        end
                        1: begin
                            bi[b][l] = DW'($urandom);
                            bw[b][l] = DW'($urandom);
                        end
                        default: begin
                            bi[b][l] = pat_ifm[l];
                            bw[b][l] = pat_w[l];
                        end
                    endcase
                    acc += longint'(bi[b][l]) * longint'(bw[b][l]);
                end
            end
            exp_q.push_back('{data: model(acc, shift, relu), addr: AW'(base + AW'(n)), last: (n == en - 1)});
            for (int b = 0; b < el; b++) begin
                if (b > 0 && (gaps == 1 || (gaps == 2 && $urandom % 3 == 0))) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
                drive_beat(bi[b], bw[b], ok);
                if (!ok) begin
                    fail_now("in_ready_timeout");
                    in_valid = 1'b0;
                    return;
                end
                acc_cnt++;
            end
            in_valid = 1'b0;
            check("in_ready_drop", in_ready, 0);
        end
        t = 0;
        while ((busy || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) fail_now("job_end_timeout");
        @(negedge clk);
        check("accept_count", acc_cnt, el * en);
        check("done_count", done_cnt, jobs);
    endtask

    task automatic set_pat(input int a0, a1, a2, a3, input int w0, w1, w2, w3);
        pat_ifm[0] = DW'(a0); pat_ifm[1] = DW'(a1); pat_ifm[2] = DW'(a2); pat_ifm[3] = DW'(a3);
        pat_w[0]   = DW'(w0); pat_w[1]   = DW'(w1); pat_w[2]   = DW'(w2); pat_w[3]   = DW'(w3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic signed [DW-1:0] ra[LANES];
        logic signed [DW-1:0] rw[LANES];
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_len = '0; cfg_neurons = '0; cfg_shift = '0; cfg_relu = 1'b0; cfg_base = '0;
        ifm_data = '0; w_data = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);

        set_pat(1, 1, 1, 1, 1, 2, 3, 4);
        run_job(1, 1, 0, 0, 16'h0100, 2, 0, 0, 0);
        set_pat(2, 2, 2, 2, 3, 3, 3, 3);
        run_job(3, 1, 0, 0, 16'h0200, 2, 1, 0, 0);
        set_pat(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF);
        run_job(4, 1, 0, 0, 16'h0300, 2, 0, 0, 0);
        set_pat(32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, -32'h7FFF, -32'h7FFF, -32'h7FFF, -32'h7FFF);
        run_job(4, 1, 0, 0, 16'h0301, 2, 0, 0, 0);
        run_job(4, 1, 0, 1, 16'h0302, 2, 0, 0, 0);
        set_pat(16, 16, 16, 0, 16, 16, 16, 0);
        run_job(1, 1, 8, 0, 16'h0400, 2, 0, 0, 0);
        set_pat(1, 0, 0, 0, -1, 0, 0, 0);
        run_job(1, 1, 4, 0, 16'h0401, 2, 0, 0, 0);
        run_job(2, 3, 1, 0, 16'h0010, 0, 2, 1, 1);
        run_job(0, 0, 0, 0, 16'h0500, 0, 0, 0, 0);
        run_job(1, 3, 0, 0, 16'hFFFE, 0, 0, 0, 0);

        // Reset in the middle of a job, after two of four beats
        @(negedge clk);
        cfg_len = 4; cfg_neurons = 1; cfg_shift = 0; cfg_relu = 0; cfg_base = 16'h0600;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < LANES; l++) begin
                ra[l] = DW'($urandom_range(1, 100));
                rw[l] = DW'($urandom_range(1, 100));
            end
            drive_beat(ra, rw, ok);
            if (!ok) fail_now("rst_job_in_ready_timeout");
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_addr", out_addr, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_pat(1, 0, 0, 0, 5, 0, 0, 0);
        run_job(1, 1, 0, 0, 16'h0700, 2, 0, 0, 0);

        bp = 1;
        for (int j = 0; j < 10; j++) begin
            int m;
            m = $urandom % 2;
            run_job($urandom_range(0, 6), $urandom_range(0, 3),
                    (m == 0) ? $urandom_range(0, 3) : $urandom_range(10, 20),
                    1'($urandom), AW'($urandom), m, 2, 0, 0);
        end
        bp = 0;

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
